// File: rtl/spi_reg_pkg.sv
// Shared types and widths for the SPI register front end.
// The SPI_ADDR_AUTO_INC_EN build option is handled in spi_reg_if.sv, not here.
package spi_reg_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized level. Pulses are one clk wide.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_if.sv
// SPI mode-0 slave that turns command/data frames into per-register strobes.
// Optional macro SPI_ADDR_AUTO_INC_EN enables burst transfers with address auto-increment.
module spi_reg_if
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] rd_en,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   rd_data
);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_high, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .i_din(sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .i_din(cs_n),
    .o_level(w_cs_high), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_din(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sck_level, w_cs_rise, w_mosi_rise, w_mosi_fall};

  state_t              r_state;
  logic [2:0]          r_bit_cnt;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic                r_cap;

  logic [DATA_W-1:0]   w_rx_next;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic                w_cmd_rw;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [ADDR_W-1:0]   w_strobe_addr;
  logic [NUM_REGS-1:0] w_dec;
  logic [DATA_W-1:0]   w_rd_sample;

  assign w_rx_next   = {r_rx[DATA_W-2:0], w_mosi};
  assign w_cmd_addr  = w_rx_next[ADDR_W-1:0];
  assign w_cmd_rw    = w_rx_next[CMD_RW_BIT];
  assign w_next_addr = r_addr + ADDR_W'(1);
  assign w_rd_sample = (|rd_en) ? rd_data : '0;

  // In a burst read the strobe targets the register of the byte about to be shifted out.
`ifdef SPI_ADDR_AUTO_INC_EN
  assign w_strobe_addr = (r_state == CMD) ? w_cmd_addr : (r_rw ? w_next_addr : r_addr);
`else
  assign w_strobe_addr = (r_state == CMD) ? w_cmd_addr : r_addr;
`endif

  // Out-of-range addresses decode to all zeros, which suppresses every strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign w_dec[gi] = (w_strobe_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_cap     <= 1'b0;
      miso      <= 1'b0;
      wr_en     <= '0;
      rd_en     <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= '0;
      rd_en <= '0;
      if (w_cs_high) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_tx      <= '0;
        r_cap     <= 1'b0;
        miso      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              r_state   <= CMD;
              r_bit_cnt <= '0;
              r_rx      <= '0;
            end
          end
          CMD: begin
            if (w_sck_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr  <= w_cmd_addr;
                r_rw    <= w_cmd_rw;
                r_state <= DATA;
                if (w_cmd_rw) begin
                  rd_en <= w_dec;
                  r_cap <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (r_cap) begin
              r_cap <= 1'b0;
              r_tx  <= w_rd_sample;
              miso  <= w_rd_sample[DATA_W-1];
            end else if (w_sck_fall && r_bit_cnt != 3'd0) begin
              // The fall right after a byte boundary keeps bit 7 on the line.
              r_tx <= {r_tx[DATA_W-2:0], 1'b0};
              miso <= r_tx[DATA_W-2];
            end
            if (w_sck_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (!r_rw) begin
                  wr_en <= w_dec;
                  if (|w_dec) wr_data <= w_rx_next;
                end
`ifdef SPI_ADDR_AUTO_INC_EN
                if (r_rw) begin
                  rd_en <= w_dec;
                  r_cap <= 1'b1;
                end
                r_addr <= w_next_addr;
`else
                r_state <= HOLD;
`endif
              end
            end
          end
          HOLD: begin
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_if.sv
// Randomized scoreboard bench for spi_reg_if; build with +define+SPI_ADDR_AUTO_INC_EN
// to exercise bursts with address auto-increment.
module tb_spi_reg_if;

  localparam int N = 8;
`ifdef SPI_ADDR_AUTO_INC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [N-1:0] wr_en;
  logic [N-1:0] rd_en;
  logic [7:0]   wr_data;
  logic [7:0]   rd_data;

  always #5 clk = ~clk;

  spi_reg_if #(.NUM_REGS(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .rd_data(rd_data)
  );

  // Peripheral register blocks: OR-combined read bus, zero when not selected.
  logic [7:0] periph_mem [N] = '{default: 8'h00};
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N; i++) if (rd_en[i]) rd_data = rd_data | periph_mem[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (wr_en[i]) periph_mem[i] <= wr_data;
  end

  typedef struct {
    bit         is_wr;
    int         idx;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] ref_mem [N] = '{default: 8'h00};
  logic [7:0] exp_last_wr = 8'h00;
  logic [7:0] fb [4];
  logic [7:0] got [4];
  logic [7:0] exp_miso [4];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && (wr_en != '0 || rd_en != '0)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got wr_en=%b rd_en=%b expected none at %0t",
                 wr_en, rd_en, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_wr_en", 32'(wr_en), mon_e.is_wr ? (32'd1 << mon_e.idx) : 32'd0);
        chk("strobe_rd_en", 32'(rd_en), mon_e.is_wr ? 32'd0 : (32'd1 << mon_e.idx));
        if (mon_e.is_wr) chk("strobe_wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
  end

  // Reference model: derive expected strobes and read bytes from the frame contents,
  // then drive the frame as an SPI mode-0 host.
  task automatic frame(input int nb, input int nbits, input bit rst_mid, input int rst_bit);
    logic [6:0] a;
    bit         rw;
    int         c, nrd, nwr, nmiso, aa, sent;
    a     = fb[0][6:0];
    rw    = fb[0][7];
    sent  = rst_mid ? rst_bit + 1 : nbits;
    c     = (sent >= 8) ? (sent - 8) / 8 : -1;
    nmiso = 0;
    if (c >= 0) begin
      if (rw) begin
        nrd   = AUTOINC ? c + 1 : 1;
        nmiso = AUTOINC ? c : ((c >= 1) ? 1 : 0);
        for (int k = 0; k < nrd; k++) begin
          aa = (int'(a) + k) % 128;
          if (aa < N) exp_q.push_back('{is_wr: 1'b0, idx: aa, data: 8'h00});
          if (k < 4) exp_miso[k] = (aa < N) ? ref_mem[aa] : 8'h00;
        end
      end else begin
        nwr = AUTOINC ? c : ((c >= 1) ? 1 : 0);
        for (int k = 0; k < nwr; k++) begin
          aa = (int'(a) + k) % 128;
          if (aa < N) begin
            exp_q.push_back('{is_wr: 1'b1, idx: aa, data: fb[k+1]});
            ref_mem[aa] = fb[k+1];
            exp_last_wr = fb[k+1];
          end
        end
      end
    end
    $display("frame cmd=%02h data=%02h_%02h_%02h bytes=%0d bits=%0d reset_mid=%0d",
             fb[0], fb[1], fb[2], fb[3], nb, sent, rst_mid);

    cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      mosi = fb[i/8][7-(i%8)];
      #50 sck = 1'b1;
      if (i >= 8) got[i/8-1][7-(i%8)] = miso;
      #50 sck = 1'b0;
      if (rst_mid && i == rst_bit) begin
        reset = 1'b1;
        #1;
        chk("reset_mid_miso", 32'(miso), 32'd0);
        chk("reset_mid_wr_en", 32'(wr_en), 32'd0);
        chk("reset_mid_rd_en", 32'(rd_en), 32'd0);
        chk("reset_mid_wr_data", 32'(wr_data), 32'd0);
        exp_last_wr = 8'h00;
        #19 reset = 1'b0;
        break;
      end
    end
    #100 cs_n = 1'b1;
    mosi = 1'b0;
    #300;
    for (int k = 0; k < nmiso; k++) chk("miso_byte", 32'(got[k]), 32'(exp_miso[k]));
    chk("miso_idle", 32'(miso), 32'd0);
    chk("wr_data_hold", 32'(wr_data), 32'(exp_last_wr));
    chk("missing_strobes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_fb(input logic [7:0] b0, b1, b2, b3);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
  endtask

  initial begin
    int nb, total, nbits;
    logic [7:0] cmd;
    #2 reset = 1'b1;
    #18;
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    #10 reset = 1'b0;
    #30;

    set_fb(8'h00, 8'h85, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'h80, 8'h00, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'h7F, 8'hAA, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'hFF, 8'h00, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'h05, 8'h77, 8'h00, 8'h00); frame(1, 12, 1'b0, 0);
    set_fb(8'h01, 8'h3C, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'h03, 8'h5A, 8'h00, 8'h00); frame(1, 16, 1'b1, 11);
    set_fb(8'h06, 8'hC3, 8'h00, 8'h00); frame(1, 16, 1'b0, 0);
    set_fb(8'h02, 8'h11, 8'h22, 8'h33); frame(3, 32, 1'b0, 0);
    set_fb(8'h82, 8'hFF, 8'hFF, 8'hFF); frame(3, 32, 1'b0, 0);
    set_fb(8'h7E, 8'h44, 8'h55, 8'h66); frame(3, 32, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      nb  = $urandom_range(1, 3);
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:0] = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 9));
      set_fb(cmd, 8'($urandom), 8'($urandom), 8'($urandom));
      total = 8 * (1 + nb);
      nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, total - 1) : total;
      frame(nb, nbits, 1'b0, 0);
    end

    #100;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
